move_sequencer: RTL and testbench
=================================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: sole clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port moves, input, 200 bits: 50 packed 4-bit move codes; nibble 49 = bits [199:196], nibble 0 = bits [3:0].
REQ-004 SHALL have port new_moves, input, 1 bit: single-cycle load strobe qualifying moves.
REQ-005 SHALL have port motor_ready, input, 1 bit: motor driver can accept a move this cycle.
REQ-006 SHALL have port motor_done, input, 1 bit: single-cycle pulse when the accepted move has physically finished.
REQ-007 SHALL have port move, output, 4 bits: current move code (R=2, Ri=3, U=4, Ui=5, F=6, Fi=7, L=8, Li=9, B=10, Bi=11, D=12, Di=13).
REQ-008 SHALL have port move_valid, output, 1 bit: move is valid and awaiting acceptance.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port batch_done, output, 1 bit: one-cycle pulse when a batch completes.
REQ-011 SHALL have port load_err, output, 1 bit: sticky flag for a dropped load or an illegal code.

Function
REQ-012 SHALL implement states IDLE, SCAN, ISSUE, WAIT_MOTOR and DONE, holding a 200-bit batch buffer and a 6-bit nibble index idx.
REQ-013 In IDLE, on new_moves=1, SHALL capture moves into the buffer, set idx=49 and enter SCAN at the same edge.
REQ-014 In SCAN, SHALL examine exactly one nibble, buffer[idx], per cycle.
REQ-015 In SCAN, a legal code (2..13) SHALL be driven on move with move_valid=1, and the state SHALL go to ISSUE.
REQ-016 In SCAN, codes 0 and 1 are empty slots and SHALL be skipped silently.
REQ-017 In SCAN, codes 14 and 15 SHALL be skipped and SHALL set load_err.
REQ-018 In SCAN, a skipped nibble at idx=0 SHALL go to DONE; a skipped nibble at idx>0 SHALL decrement idx and remain in SCAN.
REQ-019 Execution order SHALL be nibble 49 first, then downward, i.e. the most significant nonzero nibble executes first.
REQ-020 In ISSUE, move and move_valid SHALL be held stable until an edge with motor_ready=1; at that edge move_valid SHALL go to 0 and the state SHALL go to WAIT_MOTOR.
REQ-021 In WAIT_MOTOR, on motor_done=1, SHALL go to DONE if idx=0, otherwise decrement idx and go to SCAN.
REQ-022 motor_done SHALL be ignored outside WAIT_MOTOR.
REQ-023 DONE SHALL last one cycle, assert batch_done for that cycle, and return to IDLE.
REQ-024 new_moves=1 in any non-IDLE state SHALL be dropped: buffer unchanged and load_err set.
REQ-025 new_moves=1 in the DONE cycle SHALL be dropped and SHALL set load_err.
REQ-026 Latency: if new_moves is sampled at edge E0 and nibble 49 is legal, move_valid SHALL be 1 after edge E1; each skipped nibble SHALL add exactly one cycle.
REQ-027 An all-empty batch SHALL pass 50 SCAN cycles, then pulse batch_done with move_valid never asserted.
REQ-028 load_err SHALL clear only on reset.

Reset
REQ-029 On reset=1 at an edge, SHALL enter IDLE with move=0, move_valid=0, busy=0, batch_done=0, load_err=0, idx=0 and buffer=0, regardless of current state.
REQ-030 Reset mid-batch SHALL abandon all remaining moves.
REQ-031 Reset SHALL take priority over new_moves, motor_ready and motor_done in the same cycle.

Configuration
REQ-032 With MOVE_SEQ_COUNT_EN defined, SHALL add output move_count, 6 bits: number of moves accepted (motor_ready handshakes) in the current batch.
REQ-033 With MOVE_SEQ_COUNT_EN defined, move_count SHALL clear on reset and on a batch load, and SHALL hold its value after batch_done until the next load.
REQ-034 Without MOVE_SEQ_COUNT_EN, the move_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Load moves={L,Ri,Fi,U,Ui} (low 20 bits, rest 0) with motor_ready=1 and motor_done 2 cycles after each acceptance -> moves issued in order 8,3,7,4,5; one batch_done pulse; move_count=5.
REQ-036 Load nibble 49=6 only with motor_ready held 0 for 10 cycles -> move=6 and move_valid=1 stable all 10 cycles; accepted on the first cycle motor_ready=1.
REQ-037 Load an all-zero vector -> busy for exactly 50 SCAN cycles plus 1 DONE cycle; batch_done pulses; move_valid never 1.
REQ-038 Pulse new_moves during WAIT_MOTOR -> load_err=1; the remaining sequence is unchanged.
REQ-039 Load nibble 0=15 and nibble 1=2 -> only move 2 is issued; load_err=1.
REQ-040 Assert reset while in ISSUE -> next cycle move_valid=0, busy=0; a subsequent load runs normally from nibble 49.

Source files
------------

// File: rtl/move_sequencer.sv
// Issues packed 4-bit move codes from nibble 49 down to nibble 0, with a ready/done motor handshake.
// Optional MOVE_SEQ_COUNT_EN adds move_count, the number of moves accepted in the current batch.
module move_sequencer (
  input  logic         clock,
  input  logic         reset,
  input  logic [199:0] moves,
  input  logic         new_moves,
  input  logic         motor_ready,
  input  logic         motor_done,
  output logic [3:0]   move,
  output logic         move_valid,
  output logic         busy,
  output logic         batch_done,
  output logic         load_err
`ifdef MOVE_SEQ_COUNT_EN
  ,
  output logic [5:0]   move_count
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SCAN       = 3'd1,
    ISSUE      = 3'd2,
    WAIT_MOTOR = 3'd3,
    DONE       = 3'd4
  } state_t;

  state_t         state_q;
  logic [199:0]   buf_q;
  logic [5:0]     idx_q;
  logic [3:0]     move_q;
  logic           move_valid_q;
  logic           busy_q;
  logic           batch_done_q;
  logic           load_err_q;
`ifdef MOVE_SEQ_COUNT_EN
  logic [5:0]     count_q;
`endif

  logic [3:0] nib;
  logic       nib_legal;
  logic       nib_bad;

  assign nib       = buf_q[{idx_q, 2'b00} +: 4];
  assign nib_legal = (nib >= 4'd2) && (nib <= 4'd13);
  assign nib_bad   = (nib >= 4'd14);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      idx_q        <= '0;
      move_q       <= '0;
      move_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      batch_done_q <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef MOVE_SEQ_COUNT_EN
      count_q      <= '0;
`endif
    end else begin
      batch_done_q <= 1'b0;
      // A load strobe outside IDLE (including the DONE cycle) is dropped.
      if (new_moves && (state_q != IDLE)) begin
        load_err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (new_moves) begin
            buf_q   <= moves;
            idx_q   <= 6'd49;
            busy_q  <= 1'b1;
            state_q <= SCAN;
`ifdef MOVE_SEQ_COUNT_EN
            count_q <= '0;
`endif
          end
        end
        SCAN: begin
          if (nib_legal) begin
            move_q       <= nib;
            move_valid_q <= 1'b1;
            state_q      <= ISSUE;
          end else begin
            if (nib_bad) begin
              load_err_q <= 1'b1;
            end
            if (idx_q == 6'd0) begin
              batch_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              idx_q <= idx_q - 6'd1;
            end
          end
        end
        ISSUE: begin
          if (motor_ready) begin
            move_valid_q <= 1'b0;
            state_q      <= WAIT_MOTOR;
`ifdef MOVE_SEQ_COUNT_EN
            count_q      <= count_q + 6'd1;
`endif
          end
        end
        WAIT_MOTOR: begin
          if (motor_done) begin
            if (idx_q == 6'd0) begin
              batch_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              idx_q   <= idx_q - 6'd1;
              state_q <= SCAN;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q       <= 1'b0;
          move_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign move       = move_q;
  assign move_valid = move_valid_q;
  assign busy       = busy_q;
  assign batch_done = batch_done_q;
  assign load_err   = load_err_q;
`ifdef MOVE_SEQ_COUNT_EN
  assign move_count = count_q;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: ordering, hold under backpressure, empty batch, dropped loads, illegal codes, reset.
module tb_move_sequencer;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [199:0] moves = '0;
  logic         new_moves = 1'b0;
  logic         motor_ready = 1'b0;
  logic         motor_done = 1'b0;
  logic [3:0]   move;
  logic         move_valid;
  logic         busy;
  logic         batch_done;
  logic         load_err;
`ifdef MOVE_SEQ_COUNT_EN
  logic [5:0]   move_count;
`endif

  int errs = 0;
  int checks = 0;

  logic [3:0] acc_q[$];
  int         n_bd, n_vld, n_busy;
  bit         tmo;

  move_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .moves       (moves),
    .new_moves   (new_moves),
    .motor_ready (motor_ready),
    .motor_done  (motor_done),
    .move        (move),
    .move_valid  (move_valid),
    .busy        (busy),
    .batch_done  (batch_done),
    .load_err    (load_err)
`ifdef MOVE_SEQ_COUNT_EN
    ,
    .move_count  (move_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    new_moves = 1'b0;
    motor_ready = 1'b0;
    motor_done = 1'b0;
    moves = '0;
    step();
    reset = 1'b0;
  endtask

  // Loads vec, then acts as a motor: always ready, motor_done two cycles after each acceptance.
  task automatic run(input logic [199:0] vec, input bit mid_load, input bit load_in_done);
    int pend;
    bit hs;
    bit mid_used;
    acc_q.delete();
    n_bd = 0; n_vld = 0; n_busy = 0; pend = 0; mid_used = 0;
    moves = vec;
    new_moves = 1'b1;
    motor_ready = 1'b1;
    step();
    new_moves = 1'b0;
    moves = {200{1'b1}};
    for (int c = 0; c < 400 && busy; c++) begin
      n_busy++;
      if (batch_done) n_bd++;
      if (move_valid) n_vld++;
      motor_done = (pend == 1);
      new_moves = (mid_load && !mid_used && pend == 1) || (load_in_done && batch_done);
      if (mid_load && pend == 1) mid_used = 1;
      hs = move_valid && motor_ready;
      if (hs) acc_q.push_back(move);
      step();
      if (hs) pend = 2;
      else if (pend > 0) pend--;
    end
    tmo = busy;
    motor_done = 1'b0;
    new_moves = 1'b0;
    motor_ready = 1'b0;
    moves = '0;
  endtask

  function automatic logic [19:0] packed_acc();
    logic [19:0] got;
    got = '0;
    foreach (acc_q[i]) got = {got[15:0], acc_q[i]};
    return got;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    new_moves = 1'b1;
    motor_ready = 1'b1;
    motor_done = 1'b1;
    moves = {200{1'b1}};
    step();
    checks++;
    if ({move, move_valid, busy, batch_done, load_err} !== 8'h00) begin
      errs++;
      $display("FAIL reset_outputs: got move=%h vld=%b busy=%b bd=%b err=%b, expected all 0",
               move, move_valid, busy, batch_done, load_err);
    end
`ifdef MOVE_SEQ_COUNT_EN
    checks++;
    if (move_count !== 6'd0) begin
      errs++;
      $display("FAIL reset_count: got %0d expected 0", move_count);
    end
`endif
    reset = 1'b0;
    new_moves = 1'b0;
    motor_ready = 1'b0;
    motor_done = 1'b0;
    moves = '0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_no_load: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_order();
    do_reset();
    run(200'h83745, 1'b0, 1'b0);
    checks++;
    if (tmo || acc_q.size() != 5 || packed_acc() !== 20'h83745) begin
      errs++;
      $display("FAIL order: got %0d moves %h (timeout=%b) expected 5 moves 83745", acc_q.size(), packed_acc(), tmo);
    end
    checks++;
    if (n_bd != 1) begin
      errs++;
      $display("FAIL order_batch_done: got %0d pulses expected 1", n_bd);
    end
    checks++;
    if (load_err !== 1'b0) begin
      errs++;
      $display("FAIL order_load_err: got %b expected 0", load_err);
    end
`ifdef MOVE_SEQ_COUNT_EN
    checks++;
    if (move_count !== 6'd5) begin
      errs++;
      $display("FAIL order_count: got %0d expected 5", move_count);
    end
`endif
  endtask

  task automatic test_hold();
    int bad;
    int n;
    do_reset();
    moves = {4'h6, 196'h0};
    new_moves = 1'b1;
    motor_ready = 1'b0;
    step();
    new_moves = 1'b0;
    moves = '0;
    checks++;
    if (busy !== 1'b1 || move_valid !== 1'b0) begin
      errs++;
      $display("FAIL hold_load_edge: busy=%b vld=%b expected 1 0", busy, move_valid);
    end
    step();
    checks++;
    if (move_valid !== 1'b1 || move !== 4'd6) begin
      errs++;
      $display("FAIL hold_latency: vld=%b move=%0d expected 1 6", move_valid, move);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(move_valid === 1'b1 && move === 4'd6 && busy === 1'b1)) bad++;
      motor_done = (i == 4);
      step();
    end
    motor_done = 1'b0;
    checks++;
    if (bad != 0 || move_valid !== 1'b1) begin
      errs++;
      $display("FAIL hold_stable: %0d unstable cycles, vld=%b, expected 0 and 1", bad, move_valid);
    end
    motor_ready = 1'b1;
    step();
    motor_ready = 1'b0;
    checks++;
    if (move_valid !== 1'b0) begin
      errs++;
      $display("FAIL hold_accept: vld=%b expected 0", move_valid);
    end
    motor_done = 1'b1;
    step();
    motor_done = 1'b0;
    n = 0;
    while (!batch_done && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n != 49) begin
      errs++;
      $display("FAIL hold_tail_scan: got %0d cycles expected 49", n);
    end
    step();
  endtask

  task automatic test_empty();
    do_reset();
    run('0, 1'b0, 1'b1);
    checks++;
    if (tmo || n_busy != 51) begin
      errs++;
      $display("FAIL empty_busy: got %0d busy cycles (timeout=%b) expected 51", n_busy, tmo);
    end
    checks++;
    if (n_bd != 1 || n_vld != 0) begin
      errs++;
      $display("FAIL empty_flags: bd=%0d vld=%0d expected 1 0", n_bd, n_vld);
    end
    step();
    checks++;
    if (busy !== 1'b0 || load_err !== 1'b1) begin
      errs++;
      $display("FAIL empty_done_drop: busy=%b err=%b expected 0 1", busy, load_err);
    end
  endtask

  task automatic test_drop();
    do_reset();
    run(200'h83745, 1'b1, 1'b0);
    checks++;
    if (tmo || acc_q.size() != 5 || packed_acc() !== 20'h83745) begin
      errs++;
      $display("FAIL drop_order: got %0d moves %h expected 5 moves 83745", acc_q.size(), packed_acc());
    end
    checks++;
    if (load_err !== 1'b1 || n_bd != 1) begin
      errs++;
      $display("FAIL drop_err: err=%b bd=%0d expected 1 1", load_err, n_bd);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    run(200'h2F, 1'b0, 1'b0);
    checks++;
    if (tmo || acc_q.size() != 1 || packed_acc() !== 20'h2) begin
      errs++;
      $display("FAIL illegal_moves: got %0d moves %h expected 1 move 2", acc_q.size(), packed_acc());
    end
    checks++;
    if (load_err !== 1'b1 || n_bd != 1) begin
      errs++;
      $display("FAIL illegal_err: err=%b bd=%0d expected 1 1", load_err, n_bd);
    end
  endtask

  task automatic test_reset_issue();
    do_reset();
    moves = {4'h6, 196'h0};
    new_moves = 1'b1;
    step();
    new_moves = 1'b0;
    step();
    checks++;
    if (move_valid !== 1'b1) begin
      errs++;
      $display("FAIL rst_issue_pre: vld=%b expected 1", move_valid);
    end
    reset = 1'b1;
    new_moves = 1'b1;
    motor_ready = 1'b1;
    motor_done = 1'b1;
    moves = {200{1'b1}};
    step();
    checks++;
    if (move_valid !== 1'b0 || busy !== 1'b0 || move !== 4'd0 || load_err !== 1'b0) begin
      errs++;
      $display("FAIL rst_issue: vld=%b busy=%b move=%0d err=%b expected 0 0 0 0", move_valid, busy, move, load_err);
    end
    reset = 1'b0;
    new_moves = 1'b0;
    motor_ready = 1'b0;
    motor_done = 1'b0;
    moves = '0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_issue_idle: busy=%b expected 0", busy);
    end
    run(200'h83745, 1'b0, 1'b0);
    checks++;
    if (tmo || packed_acc() !== 20'h83745 || acc_q.size() != 5 || n_bd != 1 || load_err !== 1'b0) begin
      errs++;
      $display("FAIL rst_issue_rerun: moves %h n=%0d bd=%0d err=%b expected 83745 5 1 0",
               packed_acc(), acc_q.size(), n_bd, load_err);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_hold();
    test_empty();
    test_drop();
    test_illegal();
    test_reset_issue();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
